ev_pwm_ramp_driver: RTL

//  Downstream stage of the EV motor controller: consumes the 8-bit motor speed command and drives the inverter leg.

---
 rtl/ev_pwm_ramp_driver.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/ev_pwm_ramp_driver.sv
// Inverter-leg driver for the EV motor controller.
// Slew-limits the 8-bit speed command and halves it while the motor is overheated.
// Drives complementary high/low-side PWM with a programmable dead time.
// The applied duty is shadowed, so it only changes at the start of a PWM period.
module ev_pwm_ramp_driver #(
    parameter int PRESCALE  = 16,  // clk cycles per PWM counter increment
    parameter int RAMP_DIV  = 64,  // clk cycles between ramp steps
    parameter int RAMP_STEP = 4,   // duty LSBs moved per ramp step
    parameter int DEAD_TIME = 3    // clk cycles both gates are held off at each edge
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       estop,
    input  logic       fault_in,
    input  logic [7:0] target_speed,
    input  logic       target_valid,
    output logic       pwm_hi,
    output logic       pwm_lo,
    output logic [7:0] duty,
    output logic [1:0] state,
    output logic       at_target
);

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_RAMP  = 2'd1,
        ST_HOLD  = 2'd2,
        ST_FAULT = 2'd3
    } state_e;

    localparam int              PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int              RW         = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [PW-1:0]   PRESC_LAST = PW'(PRESCALE - 1);
    localparam logic [RW-1:0]   RAMP_LAST  = RW'(RAMP_DIV - 1);
    localparam logic [7:0]      STEP       = 8'(RAMP_STEP);
    localparam logic [3:0]      DT         = 4'(DEAD_TIME);

    state_e          state_q, state_d;
    logic [7:0]      tgt_q, tgt_d;
    logic [7:0]      ramp_duty_q, ramp_duty_d;
    logic [7:0]      duty_q, duty_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [7:0]      pwm_cnt_q, pwm_cnt_d;
    logic [RW-1:0]   rtmr_q, rtmr_d;
    logic            raw_prev_q, raw_prev_d;
    logic [3:0]      dt_cnt_q, dt_cnt_d;

    logic [7:0]      eff;
    logic [7:0]      diff;
    logic            clr;
    logic            ramping;
    logic            ramp_tc;
    logic            presc_tc;
    logic            raw;
    logic [3:0]      dt_elapsed;
    logic            dt_done;
    logic            gate_on;

    // Effective target, shared helper terms and the gated gate-driver outputs.
    always_comb begin
        eff        = (state_q == ST_FAULT) ? {1'b0, tgt_q[7:1]} : tgt_q;
        diff       = (eff >= ramp_duty_q) ? (eff - ramp_duty_q) : (ramp_duty_q - eff);
        // Going to OFF, or sitting in OFF, holds every timer and the duty path at zero.
        clr        = estop || !enable || (state_q == ST_OFF);
        ramping    = (state_q == ST_RAMP) || (state_q == ST_FAULT);
        ramp_tc    = (rtmr_q == RAMP_LAST);
        presc_tc   = (presc_q == PRESC_LAST);
        raw        = (pwm_cnt_q < duty_q);
        // A raw edge this cycle restarts the dead-time count, cancelling any pending edge.
        dt_elapsed = (raw != raw_prev_q) ? 4'd0 : dt_cnt_q;
        dt_done    = (dt_elapsed == DT);
        // estop is taken straight from the pin so both gates drop in the same cycle.
        gate_on    = (state_q != ST_OFF) && !estop;
        pwm_hi     = gate_on && raw && dt_done;
        pwm_lo     = gate_on && !raw && dt_done;
        duty       = duty_q;
        state      = state_q;
        at_target  = (state_q == ST_HOLD);
    end

    // Next-state logic; estop and enable override every state.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        state_d = state_q;
        if (estop || !enable) begin
            state_d = ST_OFF;
        end else begin
            case (state_q)
                ST_OFF:   state_d = ST_RAMP;
                ST_RAMP:  if (fault_in)                 state_d = ST_FAULT;
                          else if (ramp_duty_q == eff)  state_d = ST_HOLD;
                ST_HOLD:  if (fault_in)                 state_d = ST_FAULT;
                          else if (ramp_duty_q != eff)  state_d = ST_RAMP;
                ST_FAULT: if (!fault_in)                state_d = ST_RAMP;
                default:  state_d = ST_OFF;
            endcase
        end
    end

    // Datapath next values: target latch, ramp, PWM counters, shadow duty, dead time.
    always_comb begin
        tgt_d       = tgt_q;
        ramp_duty_d = ramp_duty_q;
        rtmr_d      = '0;
        if (target_valid && enable) tgt_d = target_speed;

        if (ramping) begin
            rtmr_d = ramp_tc ? '0 : rtmr_q + 1'b1;
            if (ramp_tc) begin
                if (diff <= STEP)             ramp_duty_d = eff;
                else if (eff > ramp_duty_q)   ramp_duty_d = ramp_duty_q + STEP;
                else                          ramp_duty_d = ramp_duty_q - STEP;
            end
        end

        presc_d    = presc_tc ? '0 : presc_q + 1'b1;
        pwm_cnt_d  = presc_tc ? pwm_cnt_q + 8'd1 : pwm_cnt_q;
        duty_d     = (presc_tc && (pwm_cnt_q == 8'hFF)) ? ramp_duty_q : duty_q;
        raw_prev_d = raw;
        dt_cnt_d   = dt_done ? dt_elapsed : dt_elapsed + 4'd1;

        if (clr) begin
            ramp_duty_d = '0;
            rtmr_d      = '0;
            presc_d     = '0;
            pwm_cnt_d   = '0;
            duty_d      = '0;
            raw_prev_d  = 1'b0;
            dt_cnt_d    = '0;
        end
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_OFF;
            tgt_q       <= '0;
            ramp_duty_q <= '0;
            duty_q      <= '0;
            presc_q     <= '0;
            pwm_cnt_q   <= '0;
            rtmr_q      <= '0;
            raw_prev_q  <= 1'b0;
            dt_cnt_q    <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q     <= state_d;
            tgt_q       <= tgt_d;
            ramp_duty_q <= ramp_duty_d;
            duty_q      <= duty_d;
            presc_q     <= presc_d;
            pwm_cnt_q   <= pwm_cnt_d;
            rtmr_q      <= rtmr_d;
            raw_prev_q  <= raw_prev_d;
            dt_cnt_q    <= dt_cnt_d;
        end
    end

endmodule
